// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / 8;

  // Access size encoding as carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Byte-lane masks for a lane-0 aligned access of each size.
  localparam logic [LANES-1:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [LANES-1:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [LANES-1:0] LANE_MASK_WORD = 4'b1111;

  // Lanes touched by an access of the given size at the given byte offset.
  function automatic logic [LANES-1:0] lane_mask(input size_e size, input logic [1:0] offset);
    logic [LANES-1:0] base;
    case (size)
      SZ_BYTE: base = LANE_MASK_BYTE;
      SZ_HALF: base = LANE_MASK_HALF;
      SZ_WORD: base = LANE_MASK_WORD;
      default: base = '0;
    endcase
    return base << offset;
  endfunction

  // Expand a per-lane mask into a per-bit mask.
  function automatic logic [WORD_W-1:0] expand_mask(input logic [LANES-1:0] lanes);
    logic [WORD_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      bits[i*8 +: 8] = {8{lanes[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory port bundle for lsu_mem_master.
interface lsu_mem_master_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  // The LSU: memory master, request target.
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  // The surrounding core and memory.
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data_c,
  output logic [WORD_W-1:0] merge_data_c
);

  logic [4:0]        shamt;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] inserted;
  logic [WORD_W-1:0] bit_mask;

  assign shamt = {offset, 3'b000};

  // Move the addressed lane down to bit 0 and extend it.
  always_comb begin
    shifted     = old_word >> shamt;
    load_data_c = old_word;
    case (size)
      SZ_BYTE: load_data_c = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_c = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_c = old_word;
    endcase
  end

  // Replace only the target lanes of the old word with the store data.
  always_comb begin
    bit_mask     = expand_mask(lane_mask(size, offset));
    inserted     = store_data << shamt;
    merge_data_c = (old_word & ~bit_mask) | (inserted & bit_mask);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed data memory.
// Byte/half/word requests; sub-word stores are read-modify-write.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// requests are errors; otherwise their low address bits are forced aligned.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned DATA_W    = 32
) (
  input logic              clk,
  input logic              rst,
  lsu_mem_master_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
  localparam logic [1:0] S_WRITE  = 2'(ST_WRITE);
  localparam logic [1:0] S_RESP   = 2'(ST_RESP);

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  size_e             req_size_c;
  logic [31:0]       req_addr_c;
  logic              req_err_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merge_data_c;

  // Classify the incoming request and normalise its address.
  always_comb begin
    req_size_c = size_e'(bus.req_size);
    req_addr_c = bus.req_addr;
    req_err_c  = (bus.req_addr[31:2] >= 30'(MEM_WORDS)) || (req_size_c == SZ_ILL);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size_c == SZ_HALF && bus.req_addr[0]) req_err_c = 1'b1;
    if (req_size_c == SZ_WORD && bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
`else
    if (req_size_c == SZ_HALF) req_addr_c[0] = 1'b0;
    if (req_size_c == SZ_WORD) req_addr_c[1:0] = 2'b00;
`endif
  end

  lsu_lane_align u_lane_align (
    .size         (size_q),
    .is_unsigned  (uns_q),
    .offset       (off_q),
    .old_word     (bus.mem_rdata),
    .store_data   (wdata_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          ready_d = 1'b0;
          we_d    = bus.req_we;
          size_d  = req_size_c;
          uns_d   = bus.req_unsigned;
          off_d   = req_addr_c[1:0];
          wdata_d = bus.req_wdata;
          if (req_err_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = S_ACCESS;
            mem_addr_d = {req_addr_c[31:2], 2'b00};
            if (bus.req_we && req_size_c == SZ_WORD) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = bus.req_wdata;
            end
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_c;
        end else if (size_q == SZ_WORD) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d     = S_WRITE;
          mem_addr_d  = mem_addr_q;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_data_c;
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, output and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  // Write enable is suppressed while rst is high so an abandoned RMW never lands.
  assign bus.mem_we    = mem_we_q & ~rst;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the word-addressed data memory port on behalf of the core. Accepts one byte, halfword or word request per handshake and issues word-aligned memory accesses. Sub-word stores are done as read-modify-write over two memory cycles. Loads are sign- or zero-extended, and the result or error is returned as a one-cycle response pulse. Sits between the core's execute stage and the data memory, which reads combinationally and writes on the clock edge.

Parameters:
MEM_WORDS, 64, number of 32-bit words behind the port; a word index >= MEM_WORDS is an out-of-range error.
DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request (high only in IDLE).
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  extended load data; 0 for stores and errors.
rsp_err  output  1  valid with rsp_valid: misaligned, out-of-range or illegal size.
mem_we  output  1  memory write enable.
mem_addr  output  32  word-aligned byte address, {addr[31:2],2'b00}.
mem_wdata  output  32  memory write data.
mem_rdata  input  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset: state IDLE. req_ready=1. rsp_valid=0, rsp_rdata=0, rsp_err=0. mem_we=0, mem_addr=0, mem_wdata=0. All request registers cleared. Reset mid-operation abandons the access; no write is issued after rst is asserted.
- States:
  - IDLE: on req_valid&&req_ready, register the request. If it is an error go to RESP, else go to ACCESS.
  - ACCESS, load: capture the extended lane of mem_rdata, then go to RESP.
  - ACCESS, word store: mem_we=1, mem_wdata=req_wdata, then go to RESP.
  - ACCESS, sub-word store: latch mem_rdata, mem_we=0, then go to WRITE.
  - WRITE: mem_we=1, mem_wdata=latched word with the target lanes replaced, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Latency, counting the accept edge as cycle 0:
  - Error: rsp_valid in cycle 1.
  - Load or word store: cycle 2.
  - Sub-word store: cycle 3.
- The next request can be accepted in the cycle after RESP.
- Error conditions:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - Illegal size: req_size=11.
  - An errored request never asserts mem_we. It returns rsp_err=1 and rsp_rdata=0.
- Lane selection:
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1]*16.
  - Sign extension uses the lane's MSB.
- mem_addr holds the registered aligned address from ACCESS through WRITE. It is 0 in IDLE and RESP.
- req_valid while not ready is ignored; the requester must hold the request.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned half/word requests return rsp_err=1 as described above.
- Undefined: misalignment is not an error. Low address bits are forced to the natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.
- Out-of-range and illegal size remain errors in both builds.

Decomposition:
- Package lsu_pkg holds:
  - The size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - The state enum (IDLE, ACCESS, WRITE, RESP).
  - Byte-lane mask constants.
- One combinational sub-module, lsu_lane_align:
  - Load path: extract the lane and sign/zero-extend.
  - Store path: merge the store data into the old word using the lane mask.
- The FSM and registers stay in lsu_mem_master.

Test Plan:
- Word store: addr 0x10, data 0xDEADBEEF. Expect mem_we high for exactly 1 cycle with mem_addr 0x10, and rsp_valid at cycle 2 with rsp_err=0. A word load from 0x10 then returns 0xDEADBEEF at cycle 2.
- Byte store: memory word 0x10 = 0xDEADBEEF, store 0x55 to addr 0x12. Expect a read in cycle 1, then mem_wdata 0xDE55BEEF with mem_we in cycle 2, and rsp_valid at cycle 3.
- Signed byte load from 0x13 (byte 0xDE) returns 0xFFFFFFDE. The same load with req_unsigned=1 returns 0x000000DE. A signed half load from 0x10 (half 0xBEEF) returns 0xFFFFBEEF.
- Misaligned word load from 0x11:
  - With LSU_MISALIGN_TRAP_EN: rsp_err=1 at cycle 1, no memory access.
  - Without it: data from word 0x10, rsp_err=0.
- Out-of-range store to word index 64 (addr 0x100) with default MEM_WORDS: rsp_err=1, mem_we never asserted.
- Assert rst during WRITE of a byte store: no mem_we after reset, outputs return to reset values, req_ready=1 on the next cycle.
